// File: rtl/ex_stage_handshake_div.sv
// EX stage producer side of the EX->MEM valid/allowin handshake, with a
// 32-cycle iterative restoring divider that stalls the stage while busy.
module ex_stage_handshake_div #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              excep_flush_i,
    input  logic              ex_valid_i,
    input  logic              div_en_i,
    input  logic              div_signed_i,
    input  logic              div_mod_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              mem_allowin_i,
    output logic              ex_allowin_o,
    output logic              ex_to_mem_valid_o,
    output logic [DATA_W-1:0] ex_result_o,
    output logic              div_busy_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dsor;
    logic              q_neg, r_neg, mod_sel, div_zero;

    logic              ex_ready_go, start, handoff;
    logic [DATA_W-1:0] abs1, abs2;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W+1:0] diff;
    logic              borrow;
    logic [DATA_W-1:0] quo_fix, rem_fix, div_result;

    assign start   = (state == IDLE) & ex_valid_i & div_en_i & ~excep_flush_i;
    assign handoff = ex_to_mem_valid_o & mem_allowin_i;

    assign abs1 = (div_signed_i && src1_i[DATA_W-1]) ? -src1_i : src1_i;
    assign abs2 = (div_signed_i && src2_i[DATA_W-1]) ? -src2_i : src2_i;

    // Two spare bits keep the borrow visible even when the divisor is zero
    // and the partial remainder simply accumulates the dividend.
    assign rem_sh = {rem, quo[DATA_W-1]};
    assign diff   = {1'b0, rem_sh} - {2'b00, dsor};
    assign borrow = diff[DATA_W+1];

    assign rem_fix    = r_neg ? -rem : rem;
    assign quo_fix    = div_zero ? '1 : (q_neg ? -quo : quo);
    assign div_result = mod_sel ? rem_fix : quo_fix;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = DONE;
            DONE:    if (handoff) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (excep_flush_i) state_nxt = IDLE;
    end

    always_comb begin
        ex_ready_go       = ~div_en_i | (state == DONE);
        ex_to_mem_valid_o = ex_valid_i & ex_ready_go & ~excep_flush_i;
        ex_allowin_o      = ~ex_valid_i | (ex_ready_go & mem_allowin_i) | excep_flush_i;
        ex_result_o       = div_en_i ? div_result : alu_result_i;
        div_busy_o        = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || excep_flush_i) begin
            cnt      <= '0;
            quo      <= '0;
            rem      <= '0;
            dsor     <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            mod_sel  <= 1'b0;
            div_zero <= 1'b0;
        end else if (start) begin
            cnt      <= CNT_W'(DATA_W - 1);
            quo      <= abs1;
            rem      <= '0;
            dsor     <= abs2;
            q_neg    <= div_signed_i & (src1_i[DATA_W-1] ^ src2_i[DATA_W-1]);
            r_neg    <= div_signed_i & src1_i[DATA_W-1];
            mod_sel  <= div_mod_i;
            div_zero <= (src2_i == '0);
        end else if (state == BUSY) begin
            cnt <= cnt - 1'b1;
            quo <= {quo[DATA_W-2:0], ~borrow};
            rem <= borrow ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_ex_stage_handshake_div.sv
// Directed bench for ex_stage_handshake_div: driver pushes expected results,
// a negedge monitor pops and checks them on every EX->MEM handoff.
module tb_ex_stage_handshake_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        excep_flush_i;
    logic        ex_valid_i;
    logic        div_en_i;
    logic        div_signed_i;
    logic        div_mod_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [31:0] alu_result_i;
    logic        mem_allowin_i;
    logic        ex_allowin_o;
    logic        ex_to_mem_valid_o;
    logic [31:0] ex_result_o;
    logic        div_busy_o;

    ex_stage_handshake_div #(.DATA_W(32), .CNT_W(5)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .excep_flush_i     (excep_flush_i),
        .ex_valid_i        (ex_valid_i),
        .div_en_i          (div_en_i),
        .div_signed_i      (div_signed_i),
        .div_mod_i         (div_mod_i),
        .src1_i            (src1_i),
        .src2_i            (src2_i),
        .alu_result_i      (alu_result_i),
        .mem_allowin_i     (mem_allowin_i),
        .ex_allowin_o      (ex_allowin_o),
        .ex_to_mem_valid_o (ex_to_mem_valid_o),
        .ex_result_o       (ex_result_o),
        .div_busy_o        (div_busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, req);
        end
    endtask

    // Monitor: every accepted EX->MEM transfer must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ex_to_mem_valid_o && mem_allowin_i) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_valid cyc=%0d got=%h expected=no_transfer", cyc, ex_result_o);
                end else begin
                    e = sb.pop_front();
                    if (ex_result_o !== e.res || cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL handoff cyc=%0d got=%h expected=%h at cyc=%0d",
                                 cyc, ex_result_o, e.res, e.cyc);
                    end
                end
            end
        end
    end

    task automatic set_div(input logic sgn, input logic md, input logic [31:0] a, input logic [31:0] b);
        ex_valid_i   = 1'b1;
        div_en_i     = 1'b1;
        div_signed_i = sgn;
        div_mod_i    = md;
        src1_i       = a;
        src2_i       = b;
    endtask

    // Issue a divide in the current cycle; bp = cycles of MEM backpressure once done.
    task automatic do_div(input logic sgn, input logic md, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int unsigned bp);
        int unsigned c0;
        exp_t e;
        c0 = cyc;
        set_div(sgn, md, a, b);
        mem_allowin_i = 1'b1;
        e.res = exp_res;
        e.cyc = c0 + 33 + bp;
        sb.push_back(e);
        for (int k = 0; k < 33; k++) begin
            #1;
            if (k == 0) begin
                chk("allowin_c0", {31'b0, ex_allowin_o}, 32'd0);
                chk("valid_c0", {31'b0, ex_to_mem_valid_o}, 32'd0);
            end
            if (k == 32) begin
                chk("valid_c32", {31'b0, ex_to_mem_valid_o}, 32'd0);
                chk("busy_c32", {31'b0, div_busy_o}, 32'd1);
            end
            step();
        end
        if (bp > 0) begin
            mem_allowin_i = 1'b0;
            for (int j = 0; j < int'(bp); j++) begin
                #1;
                chk("bp_valid", {31'b0, ex_to_mem_valid_o}, 32'd1);
                chk("bp_result", ex_result_o, exp_res);
                chk("bp_allowin", {31'b0, ex_allowin_o}, 32'd0);
                step();
            end
            mem_allowin_i = 1'b1;
        end
        #1;
        chk("allowin_done", {31'b0, ex_allowin_o}, 32'd1);
        step();
        ex_valid_i = 1'b0;
        div_en_i   = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; excep_flush_i = 1'b0; ex_valid_i = 1'b0; div_en_i = 1'b0;
        div_signed_i = 1'b0; div_mod_i = 1'b0; src1_i = '0; src2_i = '0;
        alu_result_i = 32'hA5A5_0001; mem_allowin_i = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        chk("rst_busy", {31'b0, div_busy_o}, 32'd0);
        chk("rst_valid", {31'b0, ex_to_mem_valid_o}, 32'd0);
        chk("rst_allowin", {31'b0, ex_allowin_o}, 32'd1);
        chk("rst_result", ex_result_o, 32'hA5A5_0001);
        step();

        // Non-divide passes through in the same cycle.
        ex_valid_i = 1'b1; div_en_i = 1'b0; alu_result_i = 32'h0000_1234;
        e.res = 32'h0000_1234; e.cyc = cyc;
        sb.push_back(e);
        #1;
        chk("alu_valid", {31'b0, ex_to_mem_valid_o}, 32'd1);
        chk("alu_allowin", {31'b0, ex_allowin_o}, 32'd1);
        chk("alu_result", ex_result_o, 32'h0000_1234);
        chk("alu_busy", {31'b0, div_busy_o}, 32'd0);
        step();
        ex_valid_i = 1'b0;
        step();

        do_div(1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0);
        do_div(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 0);
        do_div(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 0);
        do_div(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 0);
        do_div(1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 0);
        do_div(1'b1, 1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 0);
        do_div(1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 0);
        do_div(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 0);
        do_div(1'b0, 1'b0, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 0);
        do_div(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        do_div(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        do_div(1'b1, 1'b0, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 0);
        do_div(1'b1, 1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        // Backpressure for 8 cycles, then a queued divide issued right after handoff.
        do_div(1'b0, 1'b0, 32'd1000, 32'd7, 32'd142, 8);
        do_div(1'b0, 1'b1, 32'd1000, 32'd7, 32'd6, 0);
        step();

        // Flush in BUSY cycle 10: no result, stage returns to idle.
        set_div(1'b1, 1'b0, 32'd77, 32'd5);
        repeat (10) step();
        excep_flush_i = 1'b1;
        #1;
        chk("flush_valid", {31'b0, ex_to_mem_valid_o}, 32'd0);
        chk("flush_allowin", {31'b0, ex_allowin_o}, 32'd1);
        step();
        excep_flush_i = 1'b0; ex_valid_i = 1'b0; div_en_i = 1'b0;
        chk("flush_busy", {31'b0, div_busy_o}, 32'd0);
        repeat (3) step();
        do_div(1'b1, 1'b0, 32'd77, 32'd5, 32'd15, 0);

        // Flush coinciding with MEM allowin in DONE: nothing handed off.
        set_div(1'b0, 1'b0, 32'd9, 32'd3);
        repeat (33) step();
        chk("done_busy", {31'b0, div_busy_o}, 32'd1);
        excep_flush_i = 1'b1; mem_allowin_i = 1'b1;
        #1;
        chk("flush_done_valid", {31'b0, ex_to_mem_valid_o}, 32'd0);
        step();
        excep_flush_i = 1'b0; ex_valid_i = 1'b0; div_en_i = 1'b0;
        chk("flush_done_busy", {31'b0, div_busy_o}, 32'd0);
        step();

        // Reset during BUSY cycle 20 aborts the divide.
        set_div(1'b0, 1'b0, 32'd50, 32'd3);
        repeat (20) step();
        chk("pre_rst_busy", {31'b0, div_busy_o}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; ex_valid_i = 1'b0; div_en_i = 1'b0; alu_result_i = 32'hDEAD_BEEF;
        #1;
        chk("mid_rst_busy", {31'b0, div_busy_o}, 32'd0);
        chk("mid_rst_valid", {31'b0, ex_to_mem_valid_o}, 32'd0);
        chk("mid_rst_allowin", {31'b0, ex_allowin_o}, 32'd1);
        chk("mid_rst_result", ex_result_o, 32'hDEAD_BEEF);
        step();
        do_div(1'b0, 1'b1, 32'd50, 32'd3, 32'd2, 0);

        repeat (3) step();
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end

endmodule
